// File: rtl/seg_memory_if.sv
// rtl/seg_memory_if.sv - EX/MEM input and MEM/WB output bundle for the MEM stage
// master drives EX/MEM fields and observes the MEM/WB results; slave is the stage.
interface seg_memory_if #(
   parameter int LEN        = 32,
   parameter int NB_ADDR    = 5,
   parameter int NB_CTRL_WB = 2,
   parameter int NB_CTRL_M  = 9
);
   logic                  i_enable;
   logic [LEN-1:0]        i_PC_branch;
   logic [LEN-1:0]        i_ALU_result;
   logic [LEN-1:0]        i_write_data;
   logic [NB_ADDR-1:0]    i_write_register;
   logic                  i_ALU_zero;
   logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
   logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus;

   logic                  o_PC_src;
   logic [LEN-1:0]        o_PC_branch;
   logic [LEN-1:0]        o_read_data;
   logic [LEN-1:0]        o_ALU_result;
   logic [NB_ADDR-1:0]    o_write_register;
   logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus;
   logic                  o_misaligned;

   modport master (
      output i_enable, i_PC_branch, i_ALU_result, i_write_data,
             i_write_register, i_ALU_zero, i_ctrl_wb_bus, i_ctrl_mem_bus,
      input  o_PC_src, o_PC_branch, o_read_data, o_ALU_result,
             o_write_register, o_ctrl_wb_bus, o_misaligned
   );

   modport slave (
      input  i_enable, i_PC_branch, i_ALU_result, i_write_data,
             i_write_register, i_ALU_zero, i_ctrl_wb_bus, i_ctrl_mem_bus,
      output o_PC_src, o_PC_branch, o_read_data, o_ALU_result,
             o_write_register, o_ctrl_wb_bus, o_misaligned
   );
endinterface

// File: rtl/seg_memory.sv
// rtl/seg_memory.sv - MIPS MEM stage: byte/half/word data memory, branch resolve, MEM/WB register
// Memory is flop-based so that reset clears every word and loads can read combinationally.
module seg_memory #(
   parameter int LEN         = 32,
   parameter int NB_ADDR     = 5,
   parameter int NB_CTRL_WB  = 2,
   parameter int NB_CTRL_M   = 9,
   parameter int NB_MEM_ADDR = 6
) (
   input  logic        i_clk,
   input  logic        i_rst,
   seg_memory_if.slave bus
);
   localparam int DEPTH = 1 << NB_MEM_ADDR;

   logic [LEN-1:0]         r_mem [0:DEPTH-1];
   logic [LEN-1:0]         r_read_data;
   logic [LEN-1:0]         r_ALU_result;
   logic [NB_ADDR-1:0]     r_write_register;
   logic [NB_CTRL_WB-1:0]  r_ctrl_wb_bus;
   logic                   r_misaligned;

   logic                   w_mem_read;
   logic                   w_mem_write;
   logic                   w_branch_eq;
   logic                   w_branch_ne;
   logic [1:0]             w_size;
   logic                   w_unsigned;
   logic                   w_is_byte;
   logic                   w_is_half;
   logic                   w_is_word;
   logic [NB_MEM_ADDR-1:0] w_word_idx;
   logic [1:0]             w_lane;
   logic                   w_misaligned;
   logic [LEN-1:0]         w_word;
   logic [LEN-1:0]         w_shifted;
   logic [15:0]            w_half;
   logic [LEN-1:0]         w_load_data;
   logic [LEN-1:0]         w_store_mask;
   logic [LEN-1:0]         w_store_lanes;
   logic [LEN-1:0]         w_store_word;
   logic                   w_write_en;
   logic [NB_CTRL_WB-1:0]  w_ctrl_wb_next;
   logic                   w_unused_bits;

   assign w_mem_read  = bus.i_ctrl_mem_bus[0];
   assign w_mem_write = bus.i_ctrl_mem_bus[1];
   assign w_branch_eq = bus.i_ctrl_mem_bus[2];
   assign w_branch_ne = bus.i_ctrl_mem_bus[3];
   assign w_size      = bus.i_ctrl_mem_bus[5:4];
   assign w_unsigned  = bus.i_ctrl_mem_bus[6];

   // Size 10 is reserved and treated as a word access.
   assign w_is_byte = (w_size == 2'b00);
   assign w_is_half = (w_size == 2'b01);
   assign w_is_word = w_size[1];

   assign w_word_idx = bus.i_ALU_result[NB_MEM_ADDR+1:2];
   assign w_lane     = bus.i_ALU_result[1:0];

   assign w_misaligned = (w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00));

   assign w_unused_bits = ^{bus.i_ALU_result[LEN-1:NB_MEM_ADDR+2],
                            bus.i_ctrl_mem_bus[NB_CTRL_M-1:7]};

   assign bus.o_PC_src    = (w_branch_eq & bus.i_ALU_zero) | (w_branch_ne & ~bus.i_ALU_zero);
   assign bus.o_PC_branch = bus.i_PC_branch;

   assign w_word    = r_mem[w_word_idx];
   assign w_shifted = w_word >> {w_lane, 3'b000};
   assign w_half    = w_lane[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load_data = '0;
      if (w_mem_read && !w_misaligned) begin
         if (w_is_byte) begin
            w_load_data = w_unsigned ? {{(LEN-8){1'b0}}, w_shifted[7:0]}
                                     : {{(LEN-8){w_shifted[7]}}, w_shifted[7:0]};
         end else if (w_is_half) begin
            w_load_data = w_unsigned ? {{(LEN-16){1'b0}}, w_half}
                                     : {{(LEN-16){w_half[15]}}, w_half};
         end else begin
            w_load_data = w_word;
         end
      end
   end

   // Replicate the store data across lanes, then merge under a lane mask.
   always_comb begin
      w_store_mask  = '1;
      w_store_lanes = bus.i_write_data;
      if (w_is_byte) begin
         w_store_mask  = {{(LEN-8){1'b0}}, 8'hFF} << {w_lane, 3'b000};
         w_store_lanes = {4{bus.i_write_data[7:0]}};
      end else if (w_is_half) begin
         w_store_mask  = w_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         w_store_lanes = {2{bus.i_write_data[15:0]}};
      end
   end

   assign w_store_word = (w_word & ~w_store_mask) | (w_store_lanes & w_store_mask);
   assign w_write_en   = bus.i_enable & w_mem_write & ~w_misaligned;

   always_comb begin
      w_ctrl_wb_next    = bus.i_ctrl_wb_bus;
      w_ctrl_wb_next[0] = bus.i_ctrl_wb_bus[0] & ~(w_mem_read & w_misaligned);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_write_en) begin
         r_mem[w_word_idx] <= w_store_word;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_read_data      <= '0;
         r_ALU_result     <= '0;
         r_write_register <= '0;
         r_ctrl_wb_bus    <= '0;
         r_misaligned     <= 1'b0;
      end else if (bus.i_enable) begin
         r_read_data      <= w_load_data;
         r_ALU_result     <= bus.i_ALU_result;
         r_write_register <= bus.i_write_register;
         r_ctrl_wb_bus    <= w_ctrl_wb_next;
         r_misaligned     <= (w_mem_read | w_mem_write) & w_misaligned;
      end
   end

   assign bus.o_read_data      = r_read_data;
   assign bus.o_ALU_result     = r_ALU_result;
   assign bus.o_write_register = r_write_register;
   assign bus.o_ctrl_wb_bus    = r_ctrl_wb_bus;
   assign bus.o_misaligned     = r_misaligned;
endmodule
